// File: rtl/conv2d_scheduler_pkg.sv
// Shared definitions for the conv2d layer scheduler: state encoding and default geometry.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package conv2d_scheduler_pkg;

    // One-hot state encoding.
    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        LOAD_W = 5'b00010,
        RUN    = 5'b00100,
        DRAIN  = 5'b01000,
        DONE   = 5'b10000
    } state_e;

    // Default layer geometry: 28x28 output, 6 maps, 25 weights + 1 bias, 6-cycle datapath.
    localparam int DEF_OUTPUT_WIDTH       = 28;
    localparam int DEF_OUTPUT_HEIGTH      = 28;
    localparam int DEF_OUTPUT_FEATURE_MAP = 6;
    localparam int DEF_W_DEPTH            = 26;
    localparam int DEF_PIPE_LATENCY       = 6;

    // Bits needed to hold values 0..n-1 (at least 1).
    function automatic int cnt_bits(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv2d_scheduler_delay.sv
// conv_result_delay: fixed-depth shift register carrying result tags alongside the conv datapath.
// Latency: DEPTH cycles from in_dat to out_dat.
// Backpressure: none; shifts every cycle, empty slots carry zeros.
// Ports: clk, rst (async active-high), in_dat[WIDTH] in, out_dat[WIDTH] out.
module conv_result_delay #(
    parameter int DEPTH = 6,
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_dat,
    output logic [WIDTH-1:0] out_dat
);

    logic [WIDTH-1:0] pipe_q [DEPTH];
    logic [WIDTH-1:0] pipe_d [DEPTH];

    always_comb begin
        pipe_d[0] = in_dat;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign out_dat = pipe_q[DEPTH-1];

endmodule

// File: rtl/conv2d_scheduler.sv
// Layer scheduler for a 5x5 conv engine: loads weights per map, issues window coordinates, tags results.
// Latency: result tag (out_valid/out_addr/out_fmap) appears PIPE_LATENCY cycles after each win_req.
// Backpressure: win_ready=0 in RUN freezes the coordinate and injects a bubble into the result line.
// Ports: clk, rst (async active-high), start; win_ready in; w_rd_en/w_rd_addr weight reads;
//        win_req/win_x/win_y window issue; fmap_idx; out_valid/out_addr/out_fmap; busy, done.
// Optional: CONV_SCHED_PERF_CNT_EN adds stall_cnt[15:0] (saturating RUN stall count, cleared on start).
module conv2d_scheduler
    import conv2d_scheduler_pkg::*;
#(
    parameter int OUTPUT_WIDTH       = DEF_OUTPUT_WIDTH,
    parameter int OUTPUT_HEIGTH      = DEF_OUTPUT_HEIGTH,
    parameter int OUTPUT_FEATURE_MAP = DEF_OUTPUT_FEATURE_MAP,
    parameter int W_DEPTH            = DEF_W_DEPTH,
    parameter int PIPE_LATENCY       = DEF_PIPE_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        win_ready,
    output logic        w_rd_en,
    output logic [4:0]  w_rd_addr,
    output logic        win_req,
    output logic [4:0]  win_x,
    output logic [4:0]  win_y,
    output logic [2:0]  fmap_idx,
    output logic        out_valid,
    output logic [9:0]  out_addr,
    output logic [2:0]  out_fmap,
    output logic        busy,
    output logic        done
`ifdef CONV_SCHED_PERF_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    // Counter spans both LOAD_W (0..W_DEPTH incl. settle cycle) and DRAIN (0..PIPE_LATENCY-1).
    localparam int CNT_W = cnt_bits(((W_DEPTH > PIPE_LATENCY) ? W_DEPTH : PIPE_LATENCY) + 1);
    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(W_DEPTH);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(PIPE_LATENCY - 1);
    localparam logic [4:0]       X_LAST     = 5'(OUTPUT_WIDTH - 1);
    localparam logic [4:0]       Y_LAST     = 5'(OUTPUT_HEIGTH - 1);
    localparam logic [2:0]       F_LAST     = 3'(OUTPUT_FEATURE_MAP - 1);
    localparam logic [9:0]       ROW_STRIDE = 10'(OUTPUT_WIDTH);
    localparam int               DL_W       = 1 + 10 + 3;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       x_q, x_d;
    logic [4:0]       y_q, y_d;
    logic [2:0]       fmap_q, fmap_d;
    logic             issue;
    logic [9:0]       issue_addr;
    logic [DL_W-1:0]  dl_in, dl_out;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        fmap_d  = fmap_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_W;
                    cnt_d   = '0;
                    fmap_d  = '0;
                end
            end
            LOAD_W: begin
                // cnt 0..W_DEPTH-1 are reads; cnt==W_DEPTH lets the last read land.
                if (cnt_q == LOAD_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    x_d     = '0;
                    y_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                issue = win_ready;
                if (win_ready) begin
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            y_d     = '0;
                            state_d = DRAIN;
                            cnt_d   = '0;
                        end else begin
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                // Holding here for the full datapath depth keeps the next weight load
                // from overlapping the tail of this map's results.
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d = '0;
                    if (fmap_q == F_LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d = LOAD_W;
                        fmap_d  = fmap_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                fmap_d  = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            fmap_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fmap_q  <= fmap_d;
        end
    end

    assign w_rd_en    = (state_q == LOAD_W) && (cnt_q != LOAD_LAST);
    assign w_rd_addr  = 5'(cnt_q);
    assign win_req    = issue;
    assign win_x      = x_q;
    assign win_y      = y_q;
    assign fmap_idx   = fmap_q;
    assign busy       = (state_q == LOAD_W) || (state_q == RUN) || (state_q == DRAIN);
    assign done       = (state_q == DONE);

    assign issue_addr = ({5'd0, y_q} * ROW_STRIDE) + {5'd0, x_q};
    // Bubbles enter as all-zero so idle slots never carry stale tags.
    assign dl_in      = issue ? {1'b1, issue_addr, fmap_q} : '0;

    conv_result_delay #(
        .DEPTH (PIPE_LATENCY),
        .WIDTH (DL_W)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .in_dat  (dl_in),
        .out_dat (dl_out)
    );

    assign {out_valid, out_addr, out_fmap} = dl_out;

`ifdef CONV_SCHED_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == IDLE) && start) begin
            stall_cnt_d = '0;
        end else if ((state_q == RUN) && !win_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_conv2d_scheduler.sv
// Scoreboard bench for conv2d_scheduler: reference model of the layer walk in plain loops/counters.
// Latency: checks every result tag lands exactly PIPE_LATENCY cycles after its window issue.
// Backpressure: randomized and directed win_ready bubbles, ignored starts, and a mid-run reset.
module tb_conv2d_scheduler;

    localparam int W  = 28;
    localparam int H  = 28;
    localparam int F  = 6;
    localparam int WD = 26;
    localparam int PL = 6;

    logic       clk;
    logic       rst;
    logic       start;
    logic       win_ready;
    logic       w_rd_en;
    logic [4:0] w_rd_addr;
    logic       win_req;
    logic [4:0] win_x;
    logic [4:0] win_y;
    logic [2:0] fmap_idx;
    logic       out_valid;
    logic [9:0] out_addr;
    logic [2:0] out_fmap;
    logic       busy;
    logic       done;
`ifdef CONV_SCHED_PERF_CNT_EN
    logic [15:0] stall_cnt;
`endif

    conv2d_scheduler #(
        .OUTPUT_WIDTH       (W),
        .OUTPUT_HEIGTH      (H),
        .OUTPUT_FEATURE_MAP (F),
        .W_DEPTH            (WD),
        .PIPE_LATENCY       (PL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .win_ready (win_ready),
        .w_rd_en   (w_rd_en),
        .w_rd_addr (w_rd_addr),
        .win_req   (win_req),
        .win_x     (win_x),
        .win_y     (win_y),
        .fmap_idx  (fmap_idx),
        .out_valid (out_valid),
        .out_addr  (out_addr),
        .out_fmap  (out_fmap),
        .busy      (busy),
        .done      (done)
`ifdef CONV_SCHED_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard (monitor) ----------------
    typedef struct {
        int addr;
        int fmap;
        int due;
    } exp_t;

    exp_t sb[$];
    int   cyc       = 0;
    int   exp_f     = 0;
    int   exp_x     = 0;
    int   exp_y     = 0;
    int   exp_waddr = 0;
    int   run_delay = 0;
    bit   in_run    = 0;
    bit   idle      = 1;
    int   load_due  = -1;
    int   done_due  = -1;
    int   stall_exp = 0;
    int   n_wrd     = 0;
    int   n_out     = 0;
    int   n_outv    = 0;
    int   n_done    = 0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            sb.delete();
            exp_f = 0; exp_x = 0; exp_y = 0; exp_waddr = 0;
            run_delay = 0; in_run = 0; idle = 1;
            load_due = -1; done_due = -1; stall_exp = 0;
        end else begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                chk("out_valid_missing", 0, 1);
                void'(sb.pop_front());
            end
            // RUN begins two cycles after the last weight read (one settle cycle between).
            if (run_delay > 0) begin
                run_delay--;
                if (run_delay == 0) in_run = 1;
            end
            if (start && idle) begin
                idle      = 0;
                stall_exp = 0;
                load_due  = cyc + 1;
            end
            if ((w_rd_en && w_rd_addr == 5'd0) || cyc == load_due) begin
                chk("load_start", int'(w_rd_en), int'(cyc == load_due));
                load_due = -1;
            end
            if (w_rd_en) begin
                chk("w_rd_addr", int'(w_rd_addr), exp_waddr);
                chk("load_fmap", int'(fmap_idx), exp_f);
                n_wrd++;
                exp_waddr++;
                if (exp_waddr == WD) begin
                    exp_waddr = 0;
                    run_delay = 2;
                end
            end
            chk("win_req", int'(win_req), int'(in_run && win_ready));
            if (in_run && !win_ready && stall_exp < 65535) stall_exp++;
            if (win_req) begin
                chk("win_x", int'(win_x), exp_x);
                chk("win_y", int'(win_y), exp_y);
                chk("win_fmap", int'(fmap_idx), exp_f);
                e.addr = exp_y * W + exp_x;
                e.fmap = exp_f;
                e.due  = cyc + PL;
                sb.push_back(e);
                if (exp_x == W - 1) begin
                    exp_x = 0;
                    if (exp_y == H - 1) begin
                        exp_y  = 0;
                        in_run = 0;
                        if (exp_f == F - 1) begin
                            done_due = cyc + PL + 1;
                            exp_f    = 0;
                        end else begin
                            load_due = cyc + PL + 1;
                            exp_f++;
                        end
                    end else begin
                        exp_y++;
                    end
                end else begin
                    exp_x++;
                end
            end
            if (done || cyc == done_due) begin
                chk("done_cycle", int'(done), int'(cyc == done_due));
                if (done) begin
                    n_done++;
                    idle = 1;
                end
                done_due = -1;
            end
            if (out_valid) begin
                n_outv++;
                if (sb.size() == 0) begin
                    chk("out_valid_spurious", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("out_addr", int'(out_addr), e.addr);
                    chk("out_fmap", int'(out_fmap), e.fmap);
                    chk("out_latency", cyc, e.due);
                    n_out++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // mode 1: directed bubble on RUN cycles 3..7 of map 0 plus ignored starts in RUN/DRAIN.
    // mode 2: random win_ready. Runs from the first LOAD_W cycle until done.
    task automatic run_layer(input int mode, input int bound);
        int c;
        c = 1;
        forever begin
            if (mode == 1) begin
                win_ready = !(c >= 31 && c <= 35);
                start     = (c == 100 || c == 819);
            end else begin
                win_ready = ($urandom_range(0, 3) != 0);
                start     = ($urandom_range(0, 199) == 0);
            end
            @(negedge clk);
            if (mode == 1 && c >= 31 && c <= 35) begin
                chk("bubble_x", int'(win_x), 3);
                chk("bubble_y", int'(win_y), 0);
            end
            if (mode == 1 && c == 100) chk("busy_in_run", int'(busy), 1);
            if (done) begin
                chk("busy_at_done", int'(busy), 0);
                break;
            end
            if (c > bound) begin
                chk("layer_timeout", 0, 1);
                break;
            end
            step();
            c++;
        end
        start = 1'b0;
        win_ready = 1'b0;
    endtask

    initial begin
        int b_wrd, b_out, b_done, b_outv, k;
        rst       = 1'b1;
        start     = 1'b0;
        win_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_w_rd_en", int'(w_rd_en), 0);
        chk("rst_win_req", int'(win_req), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_fmap_idx", int'(fmap_idx), 0);
        chk("rst_win_xy", int'({win_x, win_y}), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Layer 1: directed bubbles, ignored starts.
        step();
        pulse_start();
        run_layer(1, 20000);
        repeat (3) step();
        chk("l1_w_rd_cycles", n_wrd, F * WD);
        chk("l1_out_count", n_out, F * W * H);
        chk("l1_done_count", n_done, 1);
        chk("l1_sb_empty", sb.size(), 0);
`ifdef CONV_SCHED_PERF_CNT_EN
        chk("l1_stall_cnt", int'(stall_cnt), stall_exp);
`endif

        // Layer 2: random flow, reset mid-run at (10,12).
        pulse_start();
        @(negedge clk);
`ifdef CONV_SCHED_PERF_CNT_EN
        chk("stall_cnt_cleared", int'(stall_cnt), 0);
`endif
        k = 0;
        forever begin
            step();
            win_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (win_x == 5'd10 && win_y == 5'd12) break;
            k++;
            if (k > 5000) begin
                chk("find_10_12_timeout", 0, 1);
                break;
            end
        end
        rst = 1'b1;
        #1;
        b_outv = n_outv;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_win_req", int'(win_req), 0);
        chk("midrst_w_rd_en", int'(w_rd_en), 0);
        chk("midrst_win_xy", int'({win_x, win_y}), 0);
        chk("midrst_fmap_idx", int'(fmap_idx), 0);
        chk("midrst_out_tag", int'({out_addr, out_fmap}), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (30) begin
            win_ready = ($urandom_range(0, 1) != 0);
            step();
        end
        chk("no_out_after_rst", n_outv - b_outv, 0);
        chk("idle_after_rst", int'(busy), 0);

        // Layer 3: fresh start after reset, random flow.
        b_wrd  = n_wrd;
        b_out  = n_out;
        b_done = n_done;
        pulse_start();
        @(negedge clk);
        chk("restart_w_rd_en", int'(w_rd_en), 1);
        chk("restart_addr", int'(w_rd_addr), 0);
        chk("restart_fmap", int'(fmap_idx), 0);
        step();
        run_layer(2, 40000);
        repeat (3) step();
        chk("l3_w_rd_cycles", n_wrd - b_wrd, F * WD);
        chk("l3_out_count", n_out - b_out, F * W * H);
        chk("l3_done_count", n_done - b_done, 1);
        chk("l3_sb_empty", sb.size(), 0);
`ifdef CONV_SCHED_PERF_CNT_EN
        chk("l3_stall_cnt", int'(stall_cnt), stall_exp);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
